// File: rtl/sd_line_fetch_pkg.sv
// Shared types and defaults for the SDRAM line prefetcher.
// The buffer address is {bank, word index}, hence the extra bit.
package sd_line_fetch_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StStream,
      StEnd,
      StDone
   } state_e;

   localparam int unsigned LINE_WORDS_DEFAULT = 1440;
   localparam int unsigned BURST_LEN_DEFAULT  = 16;

   function automatic int unsigned buf_addr_width(input int unsigned line_words);
      return 1 + $clog2(line_words);
   endfunction

   localparam int unsigned BUF_AW_DEFAULT = buf_addr_width(LINE_WORDS_DEFAULT);

endpackage

// File: rtl/sd_line_fetch.sv
// Fetches one video line from SDRAM as fixed-length bursts and writes it into
// one bank of the ping-pong line buffer read by rgb_controller.
module sd_line_fetch
   import sd_line_fetch_pkg::*;
#(
   parameter int unsigned  LINE_WORDS = LINE_WORDS_DEFAULT,
   parameter int unsigned  BURST_LEN  = BURST_LEN_DEFAULT,
   parameter logic [24:0]  BASE_ADDR  = 25'h0,
   parameter int unsigned  TIMEOUT    = 64,
   localparam int unsigned BufAw      = buf_addr_width(LINE_WORDS)
) (
   input  logic             clk_sys_99_287,
   input  logic             reset_n,
   input  logic             line_req,
   input  logic [9:0]       line_y,
   input  logic             line_bank,
   output logic             line_busy,
   output logic             line_done,
   output logic             line_error,
   output logic             line_overrun,
   output logic             sd_rd,
   output logic [24:0]      sd_rd_addr,
   input  logic             sd_data_available,
   input  logic [15:0]      sd_out,
   output logic             sd_end_burst,
   output logic             buf_wr,
   output logic [BufAw-1:0] buf_addr,
   output logic [15:0]      buf_data
);

   localparam int unsigned WordW     = BufAw - 1;
   localparam int unsigned NumBursts = LINE_WORDS / BURST_LEN;
   localparam int unsigned BurstW    = (NumBursts > 1) ? $clog2(NumBursts) : 1;
   localparam int unsigned BeatW     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int unsigned ToW       = $clog2(TIMEOUT + 1);

   state_e              state_q, state_d;
   logic [9:0]          y_q, y_d;
   logic                bank_q, bank_d;
   logic [WordW-1:0]    word_q, word_d;
   logic [BeatW-1:0]    beat_q, beat_d;
   logic [BurstW-1:0]   burst_q, burst_d;
   logic [ToW-1:0]      to_q, to_d;
   logic                abort_q, abort_d;
   logic                wr_d;
   logic [24:0]         rd_addr_d;

   logic                busy_q, done_q, error_q, overrun_q, sd_rd_q, end_q, wr_q;
   logic [24:0]         sd_rd_addr_q;
   logic [BufAw-1:0]    buf_addr_q;
   logic [15:0]         buf_data_q;

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      bank_d  = bank_q;
      word_d  = word_q;
      beat_d  = beat_q;
      burst_d = burst_q;
      to_d    = to_q;
      abort_d = abort_q;
      wr_d    = 1'b0;
      case (state_q)
         StIdle: begin
            if (line_req) begin
               y_d     = line_y;
               bank_d  = line_bank;
               word_d  = '0;
               burst_d = '0;
               abort_d = 1'b0;
               state_d = StReq;
            end
         end
         StReq: begin
            beat_d  = '0;
            to_d    = '0;
            state_d = StStream;
         end
         StStream: begin
            // Timeout measures the idle run since the last word, not burst length.
            if (sd_data_available) begin
               wr_d   = 1'b1;
               word_d = word_q + 1'b1;
               beat_d = beat_q + 1'b1;
               to_d   = '0;
               if (beat_q == BeatW'(BURST_LEN - 1)) state_d = StEnd;
            end else begin
               to_d = to_q + 1'b1;
               if (to_q == ToW'(TIMEOUT - 1)) begin
                  abort_d = 1'b1;
                  state_d = StEnd;
               end
            end
         end
         StEnd: begin
            if (abort_q || burst_q == BurstW'(NumBursts - 1)) begin
               state_d = StDone;
            end else begin
               burst_d = burst_q + 1'b1;
               state_d = StReq;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Wraps modulo 2^25, so a high BASE_ADDR rolls over to the bottom of SDRAM.
   always_comb begin
      rd_addr_d = 25'(32'(BASE_ADDR) + 32'(y_d) * LINE_WORDS + 32'(burst_d) * BURST_LEN);
   end

   always_ff @(posedge clk_sys_99_287) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         y_q          <= '0;
         bank_q       <= 1'b0;
         word_q       <= '0;
         beat_q       <= '0;
         burst_q      <= '0;
         to_q         <= '0;
         abort_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         overrun_q    <= 1'b0;
         sd_rd_q      <= 1'b0;
         sd_rd_addr_q <= '0;
         end_q        <= 1'b0;
         wr_q         <= 1'b0;
         buf_addr_q   <= '0;
         buf_data_q   <= '0;
      end else begin
         state_q   <= state_d;
         y_q       <= y_d;
         bank_q    <= bank_d;
         word_q    <= word_d;
         beat_q    <= beat_d;
         burst_q   <= burst_d;
         to_q      <= to_d;
         abort_q   <= abort_d;
         busy_q    <= (state_d != StIdle);
         done_q    <= (state_d == StDone) && !abort_d;
         error_q   <= (state_d == StDone) && abort_d;
         overrun_q <= line_req && (state_q != StIdle);
         sd_rd_q   <= (state_d == StReq);
         end_q     <= (state_d == StEnd);
         wr_q      <= wr_d;
         if (state_d == StReq) sd_rd_addr_q <= rd_addr_d;
         if (wr_d) begin
            buf_addr_q <= {bank_q, word_q};
            buf_data_q <= sd_out;
         end
      end
   end

   assign line_busy    = busy_q;
   assign line_done    = done_q;
   assign line_error   = error_q;
   assign line_overrun = overrun_q;
   assign sd_rd        = sd_rd_q;
   assign sd_rd_addr   = sd_rd_addr_q;
   assign sd_end_burst = end_q;
   assign buf_wr       = wr_q;
   assign buf_addr     = buf_addr_q;
   assign buf_data     = buf_data_q;

endmodule

// File: tb/tb_sd_line_fetch.sv
// Randomized line fetches against a transaction-level model of the prefetcher;
// a second instance with a high BASE_ADDR runs in lockstep to cover address wrap.
`timescale 1ns/1ps
module tb_sd_line_fetch;
   import sd_line_fetch_pkg::*;

   localparam int          LW        = int'(LINE_WORDS_DEFAULT);
   localparam int          BL        = int'(BURST_LEN_DEFAULT);
   localparam int          NB        = LW / BL;
   localparam int          TO        = 64;
   localparam logic [24:0] WRAP_BASE = 25'h1FFFF00;
   localparam int          BOUND     = 30000;

   logic        clk = 1'b0;
   logic        reset_n, line_req, line_bank, sd_data_available;
   logic [9:0]  line_y;
   logic [15:0] sd_out;

   logic        line_busy, line_done, line_error, line_overrun, sd_rd, sd_end_burst, buf_wr;
   logic [24:0] sd_rd_addr;
   logic [11:0] buf_addr;
   logic [15:0] buf_data;

   logic        w_line_busy, w_line_done, w_line_error, w_line_overrun, w_sd_rd;
   logic        w_sd_end_burst, w_buf_wr;
   logic [24:0] w_sd_rd_addr;
   logic [11:0] w_buf_addr;
   logic [15:0] w_buf_data;

   always #5 clk = ~clk;

   sd_line_fetch #(
      .LINE_WORDS(LINE_WORDS_DEFAULT), .BURST_LEN(BURST_LEN_DEFAULT),
      .BASE_ADDR(25'h0), .TIMEOUT(TO)
   ) u_dut (
      .clk_sys_99_287(clk), .reset_n(reset_n), .line_req(line_req), .line_y(line_y),
      .line_bank(line_bank), .line_busy(line_busy), .line_done(line_done),
      .line_error(line_error), .line_overrun(line_overrun), .sd_rd(sd_rd),
      .sd_rd_addr(sd_rd_addr), .sd_data_available(sd_data_available), .sd_out(sd_out),
      .sd_end_burst(sd_end_burst), .buf_wr(buf_wr), .buf_addr(buf_addr),
      .buf_data(buf_data)
   );

   sd_line_fetch #(
      .LINE_WORDS(LINE_WORDS_DEFAULT), .BURST_LEN(BURST_LEN_DEFAULT),
      .BASE_ADDR(WRAP_BASE), .TIMEOUT(TO)
   ) u_dut_wrap (
      .clk_sys_99_287(clk), .reset_n(reset_n), .line_req(line_req), .line_y(line_y),
      .line_bank(line_bank), .line_busy(w_line_busy), .line_done(w_line_done),
      .line_error(w_line_error), .line_overrun(w_line_overrun), .sd_rd(w_sd_rd),
      .sd_rd_addr(w_sd_rd_addr), .sd_data_available(sd_data_available), .sd_out(sd_out),
      .sd_end_burst(w_sd_end_burst), .buf_wr(w_buf_wr), .buf_addr(w_buf_addr),
      .buf_data(w_buf_data)
   );

   int          n_checks = 0;
   int          n_errors = 0;

   // Current line configuration, written only by the main sequence.
   int          cfg_y     = 0;
   logic        cfg_bank  = 1'b0;
   int          cfg_gmin  = 0;
   int          cfg_gmax  = 0;
   int          cfg_stop  = -1;
   bit          cfg_noise = 1'b0;
   logic [15:0] cfg_xor   = 16'h0;

   // Monitor state, written only by the monitor.
   int cyc = 0, req_cyc = 0, done_cyc = 0, last_wr_cyc = 0, end_gap = 0;
   int wr_idx = 0, rd_idx = 0;
   int tot_wr = 0, tot_rd = 0, tot_end = 0, tot_done = 0, tot_err = 0, tot_ovr = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] word_val(input int k);
      return 16'(k) ^ cfg_xor;
   endfunction

   function automatic logic [24:0] exp_addr(input logic [24:0] base, input int y, input int b);
      longint a;
      a = longint'(base) + longint'(y) * LW + longint'(b) * BL;
      return a[24:0];
   endfunction

   // SDRAM responder: bursts of BL words after each sd_rd, optional gaps, early stop, junk.
   initial begin : sdram_model
      bit active;
      int beat, kbase, bursts, gap, k;
      active = 1'b0; beat = 0; kbase = 0; bursts = 0; gap = 0;
      sd_data_available = 1'b0;
      sd_out = 16'h0;
      forever begin
         @(posedge clk);
         #1;
         sd_data_available = 1'b0;
         sd_out = 16'h0;
         if (!reset_n) begin
            sd_data_available = 1'b1;
            sd_out = 16'hFFFF;
         end else if (!line_busy) begin
            active = 1'b0;
            bursts = 0;
            if (cfg_noise) begin
               sd_data_available = 1'($urandom_range(1, 0));
               sd_out = 16'hDEAD;
            end
         end else if (sd_rd) begin
            active = 1'b1;
            beat = 0;
            kbase = bursts * BL;
            bursts++;
            gap = int'($urandom_range(cfg_gmax, cfg_gmin));
            if (cfg_noise) begin
               sd_data_available = 1'($urandom_range(1, 0));
               sd_out = 16'hBEEF;
            end
         end else if (active) begin
            k = kbase + beat;
            if (gap > 0) begin
               gap--;
            end else if (cfg_stop < 0 || k <= cfg_stop) begin
               sd_data_available = 1'b1;
               sd_out = word_val(k);
               beat++;
               gap = int'($urandom_range(cfg_gmax, cfg_gmin));
               if (beat == BL) active = 1'b0;
            end
         end else if (cfg_noise) begin
            sd_data_available = 1'($urandom_range(1, 0));
            sd_out = 16'hCAFE;
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         cyc++;
         if (reset_n) begin
            if (line_req && !line_busy) begin
               req_cyc = cyc;
               wr_idx = 0;
               rd_idx = 0;
            end
            if (buf_wr) begin
               check_eq("buf_addr", 32'(buf_addr), 32'({cfg_bank, 11'(wr_idx)}));
               check_eq("buf_data", 32'(buf_data), 32'(word_val(wr_idx)));
               wr_idx++;
               tot_wr++;
               last_wr_cyc = cyc;
            end
            if (sd_rd) begin
               check_eq("sd_rd_addr", 32'(sd_rd_addr), 32'(exp_addr(25'h0, cfg_y, rd_idx)));
               check_eq("wrap_rd_addr", 32'(w_sd_rd_addr),
                        32'(exp_addr(WRAP_BASE, cfg_y, rd_idx)));
               check_eq("wrap_ctrl",
                        32'({w_line_busy, w_line_done, w_line_error, w_line_overrun, w_sd_rd,
                             w_sd_end_burst, w_buf_wr}),
                        32'({line_busy, line_done, line_error, line_overrun, 1'b1,
                             sd_end_burst, buf_wr}));
               check_eq("wrap_buf", 32'({w_buf_addr, w_buf_data}), 32'({buf_addr, buf_data}));
               rd_idx++;
               tot_rd++;
            end
            if (sd_end_burst) begin
               tot_end++;
               end_gap = cyc - last_wr_cyc;
            end
            if (line_done || line_error)
               check_eq("done_err_excl", 32'(line_done & line_error), 32'd0);
            if (line_done) begin
               tot_done++;
               done_cyc = cyc;
            end
            if (line_error) tot_err++;
            if (line_overrun) tot_ovr++;
         end
      end
   end

   task automatic run_line(input int y, input bit bank, input int gmin, input int gmax,
                           input int stop, input bit noise, input bit ovr, input bit timed);
      int  s_wr, s_rd, s_end, s_done, s_err, s_ovr, n, exp_wr, exp_rd;
      bit  sent, aborted;
      cfg_y = y; cfg_bank = bank; cfg_gmin = gmin; cfg_gmax = gmax;
      cfg_stop = stop; cfg_noise = noise;
      cfg_xor = noise ? 16'($urandom) : 16'h0;
      s_wr = tot_wr; s_rd = tot_rd; s_end = tot_end;
      s_done = tot_done; s_err = tot_err; s_ovr = tot_ovr;
      @(posedge clk);
      #1;
      line_y = 10'(y);
      line_bank = bank;
      line_req = 1'b1;
      @(posedge clk);
      #1;
      line_req = 1'b0;
      check_eq("busy_start", 32'(line_busy), 32'd1);
      n = 0;
      sent = 1'b0;
      while (tot_done == s_done && tot_err == s_err && n < BOUND) begin
         if (ovr && !sent && rd_idx == 3) begin
            line_req = 1'b1;
            line_y = line_y + 10'd5;
            line_bank = ~line_bank;
            sent = 1'b1;
         end else begin
            line_req = 1'b0;
         end
         @(posedge clk);
         #1;
         n++;
      end
      line_req = 1'b0;
      check_eq("line_finished", 32'(n < BOUND), 32'd1);
      @(negedge clk);
      aborted = (stop >= 0);
      exp_wr = aborted ? stop + 1 : LW;
      exp_rd = aborted ? stop / BL + 1 : NB;
      check_eq("busy_after", 32'(line_busy), 32'd0);
      check_eq("write_count", 32'(tot_wr - s_wr), 32'(exp_wr));
      check_eq("rd_count", 32'(tot_rd - s_rd), 32'(exp_rd));
      check_eq("end_count", 32'(tot_end - s_end), 32'(exp_rd));
      check_eq("done_count", 32'(tot_done - s_done), 32'(!aborted));
      check_eq("error_count", 32'(tot_err - s_err), 32'(aborted));
      check_eq("overrun_count", 32'(tot_ovr - s_ovr), 32'(ovr));
      check_eq("end_gap", 32'(end_gap), aborted ? 32'(TO) : 32'd0);
      if (timed) check_eq("line_time", 32'(done_cyc - req_cyc + 1), 32'(NB * (BL + 2) + 2));
   endtask

   initial begin : main
      reset_n = 1'b0;
      line_req = 1'b0;
      line_y = 10'd0;
      line_bank = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check_eq("rst_ctrl",
                  32'({line_busy, line_done, line_error, line_overrun, sd_rd, sd_end_burst,
                       buf_wr, w_line_busy, w_line_done, w_line_error, w_line_overrun, w_sd_rd,
                       w_sd_end_burst, w_buf_wr}), 32'd0);
         check_eq("rst_rd_addr", 32'(sd_rd_addr), 32'd0);
         check_eq("rst_wrap_rd_addr", 32'(w_sd_rd_addr), 32'd0);
         check_eq("rst_buf", 32'({buf_addr, buf_data}), 32'd0);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("idle_busy", 32'(line_busy), 32'd0);
      check_eq("idle_writes", 32'(tot_wr), 32'd0);

      run_line(3, 1'b1, 0, 0, -1, 1'b0, 1'b0, 1'b1);
      run_line(7, 1'b0, 5, 5, -1, 1'b0, 1'b0, 1'b0);
      run_line(0, 1'b0, 0, 0, 20, 1'b0, 1'b0, 1'b0);
      run_line(10, 1'b1, 0, 3, -1, 1'b1, 1'b1, 1'b0);
      run_line(1, 1'b0, 0, 2, -1, 1'b1, 1'b0, 1'b0);
      repeat (2)
         run_line(int'($urandom_range(1023, 0)), 1'($urandom_range(1, 0)), 0, 4, -1,
                  1'b1, 1'b0, 1'b0);
      run_line(int'($urandom_range(1023, 0)), 1'($urandom_range(1, 0)), 0, 2,
               int'($urandom_range(NB - 1, 0)) * BL + int'($urandom_range(BL - 2, 0)),
               1'b1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
